// File: rtl/fetch_line_queue.sv
// fetch_line_queue: sequential instruction-line fetcher with a small line FIFO.
// Issues one 16-byte-aligned imem request at a time, buffers returned lines
// for the decoder, and on a redirect flushes the queue and drops any response
// still in flight.
// Optional feature macro: FETCH_PERF_CNT_EN enables the three perf counters;
// when undefined the perf ports are tied to zero.
module fetch_line_queue #(
    parameter int IDATAW = 128,
    parameter int IADDRW = 32,
    parameter int ISIZEW = 8,
    parameter int DEPTH = 4,
    parameter int PTRW = 2,
    parameter logic [IADDRW-1:0] RESET_VECTOR = 32'hFFFFFFF0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect_valid,
    input  logic [IADDRW-1:0] redirect_address,
    output logic              imem_valid,
    input  logic              imem_ready,
    output logic [IADDRW-1:0] imem_address,
    output logic              imem_wr_en,
    output logic [IDATAW-1:0] imem_wr_data,
    output logic [ISIZEW-1:0] imem_wr_size,
    input  logic              imem_dp_valid,
    output logic              imem_dp_ready,
    input  logic [IDATAW-1:0] imem_dp_read_data,
    output logic              fq_valid,
    input  logic              fq_ready,
    output logic [IDATAW-1:0] fq_data,
    output logic [IADDRW-1:0] fq_address,
    output logic [3:0]        fq_offset,
    output logic [31:0]       perf_lines,
    output logic [31:0]       perf_discards,
    output logic [31:0]       perf_full_stalls
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DISCARD} state_t;

    localparam logic [PTRW:0] FULL_COUNT = (PTRW+1)'(DEPTH);
    localparam logic [IADDRW-1:0] LINE_BYTES = IADDRW'(16);

    state_t            state;
    logic [IADDRW-1:0] fetch_pc;
    logic [IADDRW-1:0] req_addr;
    logic [3:0]        req_off;
    logic [3:0]        pend_off;

    logic [PTRW:0]     count;
    logic [PTRW-1:0]   rd_ptr;
    logic [PTRW-1:0]   wr_ptr;
    logic [IDATAW-1:0] data_mem [DEPTH];
    logic [IADDRW-1:0] addr_mem [DEPTH];
    logic [3:0]        off_mem  [DEPTH];

    logic q_full;
    logic req_fire;
    logic resp_fire;
    logic push;
    logic pop;

    // Requests only go out when a slot is guaranteed for the response, so
    // the data port can stay ready for the whole WAIT/DISCARD window.
    assign q_full        = (count == FULL_COUNT);
    assign imem_valid    = (state == REQ) && !q_full;
    assign imem_address  = (state == REQ) ? fetch_pc : '0;
    assign imem_dp_ready = (state == WAIT) || (state == DISCARD);
    assign imem_wr_en    = 1'b0;
    assign imem_wr_data  = '0;
    assign imem_wr_size  = '0;

    // A redirect in the same cycle as a response or a pop overrides both.
    assign req_fire  = imem_valid && imem_ready;
    assign resp_fire = imem_dp_valid && imem_dp_ready;
    assign push      = (state == WAIT) && resp_fire && !redirect_valid;
    assign pop       = fq_valid && fq_ready && !redirect_valid;

    assign fq_valid   = (count != '0);
    assign fq_data    = data_mem[rd_ptr];
    assign fq_address = addr_mem[rd_ptr];
    assign fq_offset  = off_mem[rd_ptr];

    // Fetch sequencing: redirect retargets the stream and decides whether an in-flight response must be discarded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            fetch_pc <= RESET_VECTOR;
            req_addr <= '0;
            req_off  <= '0;
            pend_off <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_address[IADDRW-1:4], 4'b0000};
            pend_off <= redirect_address[3:0];
            case (state)
                IDLE:    state <= REQ;
                REQ:     state <= req_fire ? DISCARD : REQ;
                WAIT:    state <= imem_dp_valid ? REQ : DISCARD;
                DISCARD: state <= imem_dp_valid ? REQ : DISCARD;
            endcase
        end else begin
            case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (req_fire) begin
                        req_addr <= fetch_pc;
                        req_off  <= pend_off;
                        pend_off <= '0;
                        fetch_pc <= fetch_pc + LINE_BYTES;
                        state    <= WAIT;
                    end
                end
                WAIT:    if (imem_dp_valid) state <= REQ;
                DISCARD: if (imem_dp_valid) state <= REQ;
            endcase
        end
    end

    // Line FIFO: entries are cleared on reset so the head reads zero until the first push.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_mem[i] <= '0;
                addr_mem[i] <= '0;
                off_mem[i]  <= '0;
            end
        end else if (redirect_valid) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                data_mem[wr_ptr] <= imem_dp_read_data;
                addr_mem[wr_ptr] <= req_addr;
                off_mem[wr_ptr]  <= req_off;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic        drop;
    logic [31:0] lines_cnt;
    logic [31:0] discards_cnt;
    logic [31:0] stalls_cnt;

    assign drop = resp_fire && ((state == DISCARD) || redirect_valid);

    // Free-running wrapping event counters, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lines_cnt    <= '0;
            discards_cnt <= '0;
            stalls_cnt   <= '0;
        end else begin
            if (push) lines_cnt <= lines_cnt + 1'b1;
            if (drop) discards_cnt <= discards_cnt + 1'b1;
            if ((state == REQ) && q_full) stalls_cnt <= stalls_cnt + 1'b1;
        end
    end

    assign perf_lines       = lines_cnt;
    assign perf_discards    = discards_cnt;
    assign perf_full_stalls = stalls_cnt;
`else
    assign perf_lines       = '0;
    assign perf_discards    = '0;
    assign perf_full_stalls = '0;
`endif

endmodule

// File: tb/tb_fetch_line_queue.sv
// tb_fetch_line_queue: directed test of fetch_line_queue covering sequential
// fetch with address wrap, full-queue stall, redirects in REQ/WAIT/DISCARD,
// simultaneous push/pop, pointer wrap and asynchronous reset mid-request.
module tb_fetch_line_queue;

`ifdef FETCH_PERF_CNT_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic         clk;
    logic         reset;
    logic         redirect_valid;
    logic [31:0]  redirect_address;
    logic         imem_valid;
    logic         imem_ready;
    logic [31:0]  imem_address;
    logic         imem_wr_en;
    logic [127:0] imem_wr_data;
    logic [7:0]   imem_wr_size;
    logic         imem_dp_valid;
    logic         imem_dp_ready;
    logic [127:0] imem_dp_read_data;
    logic         fq_valid;
    logic         fq_ready;
    logic [127:0] fq_data;
    logic [31:0]  fq_address;
    logic [3:0]   fq_offset;
    logic [31:0]  perf_lines;
    logic [31:0]  perf_discards;
    logic [31:0]  perf_full_stalls;

    int errors;
    int checks;
    int exp_lines;
    int exp_discards;
    int exp_stalls;

    fetch_line_queue dut (
        .clk               (clk),
        .reset             (reset),
        .redirect_valid    (redirect_valid),
        .redirect_address  (redirect_address),
        .imem_valid        (imem_valid),
        .imem_ready        (imem_ready),
        .imem_address      (imem_address),
        .imem_wr_en        (imem_wr_en),
        .imem_wr_data      (imem_wr_data),
        .imem_wr_size      (imem_wr_size),
        .imem_dp_valid     (imem_dp_valid),
        .imem_dp_ready     (imem_dp_ready),
        .imem_dp_read_data (imem_dp_read_data),
        .fq_valid          (fq_valid),
        .fq_ready          (fq_ready),
        .fq_data           (fq_data),
        .fq_address        (fq_address),
        .fq_offset         (fq_offset),
        .perf_lines        (perf_lines),
        .perf_discards     (perf_discards),
        .perf_full_stalls  (perf_full_stalls)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [127:0] lineData(input logic [31:0] addr);
        return {addr, ~addr, addr ^ 32'h5A5A5A5A, addr + 32'h0F1E2D3C};
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkFlag(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rv, input logic [31:0] ra, input logic ir,
                                 input logic dv, input logic [127:0] dd, input logic fr);
        redirect_valid    = rv;
        redirect_address  = ra;
        imem_ready        = ir;
        imem_dp_valid     = dv;
        imem_dp_read_data = dd;
        fq_ready          = fr;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkPerf(input string tag);
        checkOutput({tag, "_perf_lines"}, 128'(perf_lines), 128'(PERF_ON ? 32'(exp_lines) : 32'd0));
        checkOutput({tag, "_perf_discards"}, 128'(perf_discards), 128'(PERF_ON ? 32'(exp_discards) : 32'd0));
        checkOutput({tag, "_perf_stalls"}, 128'(perf_full_stalls), 128'(PERF_ON ? 32'(exp_stalls) : 32'd0));
    endtask

    // Expects a request for addr now, accepts it, then returns lineData(addr) one cycle later.
    task automatic fetchLine(input logic [31:0] addr);
        checkFlag("req_valid", imem_valid, 1'b1);
        checkOutput("req_addr", 128'(imem_address), 128'(addr));
        imem_ready = 1'b1;
        stepCycle();
        imem_ready = 1'b0;
        checkFlag("wait_dp_ready", imem_dp_ready, 1'b1);
        checkFlag("wait_no_req", imem_valid, 1'b0);
        imem_dp_valid     = 1'b1;
        imem_dp_read_data = lineData(addr);
        stepCycle();
        imem_dp_valid     = 1'b0;
        imem_dp_read_data = '0;
        exp_lines++;
    endtask

    task automatic popOne();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 128'h0, 1'b1);
        stepCycle();
        fq_ready = 1'b0;
    endtask

    // Directed scenario sequence.
    initial begin
        logic [31:0] a;
        errors = 0;
        checks = 0;
        exp_lines = 0;
        exp_discards = 0;
        exp_stalls = 0;
        reset = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 128'h0, 1'b0);
        repeat (2) @(negedge clk);

        // Reset state
        checkFlag("rst_imem_valid", imem_valid, 1'b0);
        checkOutput("rst_imem_address", 128'(imem_address), 128'h0);
        checkFlag("rst_dp_ready", imem_dp_ready, 1'b0);
        checkFlag("rst_fq_valid", fq_valid, 1'b0);
        checkOutput("rst_fq_data", fq_data, 128'h0);
        checkOutput("rst_fq_address", 128'(fq_address), 128'h0);
        checkOutput("rst_fq_offset", 128'(fq_offset), 128'h0);
        checkFlag("rst_wr_en", imem_wr_en, 1'b0);
        checkOutput("rst_wr_data", imem_wr_data, 128'h0);
        checkOutput("rst_wr_size", 128'(imem_wr_size), 128'h0);
        checkPerf("rst");

        reset = 1'b0;
        #1;
        checkFlag("idle_no_req", imem_valid, 1'b0);
        stepCycle();

        // 1: fill to full with address wrap, then stall
        fetchLine(32'hFFFFFFF0);
        fetchLine(32'h00000000);
        fetchLine(32'h00000010);
        fetchLine(32'h00000020);
        checkFlag("full_no_req", imem_valid, 1'b0);
        checkFlag("full_fq_valid", fq_valid, 1'b1);
        checkOutput("full_head_addr", 128'(fq_address), 128'(32'hFFFFFFF0));
        checkOutput("full_head_data", fq_data, lineData(32'hFFFFFFF0));
        repeat (3) stepCycle();
        exp_stalls = 3;
        checkFlag("stall_no_req", imem_valid, 1'b0);
        checkPerf("stall");

        // 2: redirect to 0x1237 with three entries queued
        popOne();
        exp_stalls = 4;
        checkOutput("pop_head_addr", 128'(fq_address), 128'(32'h00000000));
        checkFlag("pop_req_valid", imem_valid, 1'b1);
        checkOutput("pop_req_addr", 128'(imem_address), 128'(32'h00000030));
        applyStimulus(1'b1, 32'h00001237, 1'b0, 1'b0, 128'h0, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 128'h0, 1'b0);
        checkFlag("redir_flush", fq_valid, 1'b0);
        fetchLine(32'h00001230);
        checkOutput("redir_head_addr", 128'(fq_address), 128'(32'h00001230));
        checkOutput("redir_head_off", 128'(fq_offset), 128'h7);
        checkOutput("redir_head_data", fq_data, lineData(32'h00001230));
        fetchLine(32'h00001240);
        popOne();
        checkOutput("redir_next_addr", 128'(fq_address), 128'(32'h00001240));
        checkOutput("redir_next_off", 128'(fq_offset), 128'h0);
        checkPerf("redir");

        // 3: redirect while waiting; late response is dropped
        checkOutput("w_req_addr", 128'(imem_address), 128'(32'h00001250));
        imem_ready = 1'b1;
        stepCycle();
        applyStimulus(1'b1, 32'h00002000, 1'b0, 1'b0, 128'h0, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 128'h0, 1'b0);
        checkFlag("w_flush", fq_valid, 1'b0);
        checkFlag("w_discard_no_req", imem_valid, 1'b0);
        checkFlag("w_discard_dp_ready", imem_dp_ready, 1'b1);
        repeat (2) stepCycle();
        checkFlag("w_still_discard", imem_valid, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, {4{32'hA5A5A5A5}}, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 128'h0, 1'b0);
        exp_discards = 1;
        checkFlag("w_dropped", fq_valid, 1'b0);
        checkFlag("w_new_req", imem_valid, 1'b1);
        checkOutput("w_new_addr", 128'(imem_address), 128'(32'h00002000));
        checkPerf("w");

        // 4: redirect in the same cycle as a request handshake
        applyStimulus(1'b1, 32'h00003008, 1'b1, 1'b0, 128'h0, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 128'h0, 1'b0);
        checkFlag("hs_discard_no_req", imem_valid, 1'b0);
        checkFlag("hs_discard_dp_ready", imem_dp_ready, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, lineData(32'h00002000), 1'b0);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 128'h0, 1'b0);
        exp_discards = 2;
        checkFlag("hs_dropped", fq_valid, 1'b0);
        checkPerf("hs");
        fetchLine(32'h00003000);
        checkOutput("hs_head_addr", 128'(fq_address), 128'(32'h00003000));
        checkOutput("hs_head_off", 128'(fq_offset), 128'h8);

        // 5: simultaneous push and pop at count 2, then pointer wrap
        fetchLine(32'h00003010);
        checkOutput("pp_req_addr", 128'(imem_address), 128'(32'h00003020));
        imem_ready = 1'b1;
        stepCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, lineData(32'h00003020), 1'b1);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 128'h0, 1'b0);
        exp_lines++;
        checkOutput("pp_head_addr", 128'(fq_address), 128'(32'h00003010));
        popOne();
        checkFlag("pp_second_valid", fq_valid, 1'b1);
        checkOutput("pp_second_addr", 128'(fq_address), 128'(32'h00003020));
        checkOutput("pp_second_data", fq_data, lineData(32'h00003020));
        popOne();
        checkFlag("pp_empty", fq_valid, 1'b0);
        for (int i = 0; i < 10; i++) begin
            a = 32'h00003030 + 32'(i * 16);
            fetchLine(a);
            checkOutput("wrap_head_addr", 128'(fq_address), 128'(a));
            checkOutput("wrap_head_data", fq_data, lineData(a));
            popOne();
            checkFlag("wrap_empty", fq_valid, 1'b0);
        end
        checkPerf("wrap");

        // 6: asynchronous reset in the middle of a request
        fetchLine(32'h000030D0);
        checkOutput("ar_req_addr", 128'(imem_address), 128'(32'h000030E0));
        imem_ready = 1'b1;
        stepCycle();
        imem_ready = 1'b0;
        checkFlag("ar_in_wait", imem_dp_ready, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        exp_lines = 0;
        exp_discards = 0;
        exp_stalls = 0;
        checkFlag("ar_dp_ready", imem_dp_ready, 1'b0);
        checkFlag("ar_fq_valid", fq_valid, 1'b0);
        checkFlag("ar_imem_valid", imem_valid, 1'b0);
        checkOutput("ar_fq_address", 128'(fq_address), 128'h0);
        checkOutput("ar_fq_data", fq_data, 128'h0);
        checkPerf("ar");
        @(negedge clk);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, lineData(32'h000030E0), 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkFlag("ar_idle_no_req", imem_valid, 1'b0);
        stepCycle();
        checkFlag("ar_req_valid", imem_valid, 1'b1);
        checkOutput("ar_req_vector", 128'(imem_address), 128'(32'hFFFFFFF0));
        checkFlag("ar_late_not_queued", fq_valid, 1'b0);
        stepCycle();
        checkFlag("ar_late_still_empty", fq_valid, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 128'h0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_line_queue.md
Name: fetch_line_queue

Overview:
- Instruction-fetch front end sitting directly upstream of the memory subsystem's instruction memory port (imem_*).
- Generates sequential 16-byte-aligned line requests, one outstanding at a time, and buffers the returned 128-bit lines in a small FIFO for the decoder.
- Handles branch/exception redirects: flushes the queue and discards any in-flight response.

Parameters:
IDATAW, 128, line width in bits (16 bytes)
IADDRW, 32, address width
ISIZEW, 8, imem_wr_size width (port tie-off only)
DEPTH, 4, queue entries (power of 2)
PTRW, 2, log2(DEPTH)
RESET_VECTOR, 32'hFFFFFFF0, first fetch address after reset (line-aligned)

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-high reset
redirect_valid  input  1  redirect fetch stream this cycle
redirect_address  input  IADDRW  new byte address of the stream
imem_valid  output  1  line request valid
imem_ready  input  1  memory subsystem accepts request
imem_address  output  IADDRW  line address, bits [3:0] = 0
imem_wr_en  output  1  tied 0
imem_wr_data  output  IDATAW  tied 0
imem_wr_size  output  ISIZEW  tied 0
imem_dp_valid  input  1  line data valid
imem_dp_ready  output  1  line data accepted
imem_dp_read_data  input  IDATAW  returned line
fq_valid  output  1  queue head valid
fq_ready  input  1  decoder pops head
fq_data  output  IDATAW  head line
fq_address  output  IADDRW  head line address
fq_offset  output  4  first valid byte in head line
perf_lines  output  32  lines enqueued (see Optional Feature)
perf_discards  output  32  responses dropped
perf_full_stalls  output  32  cycles stalled by full queue

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous and active-high.
- Reset values: state=IDLE; count=0; rd/wr pointers=0; fetch_pc=RESET_VECTOR; pend_off=0; all outputs 0 (fq_data and fq_address show entry 0 contents, which are 0).
- Registers:
  - fetch_pc: next line address.
  - req_addr / req_off: address and offset of the outstanding request.
  - pend_off: offset for the next request (redirect_address[3:0] after a redirect, otherwise 0).
- State machine:
  - IDLE: next state REQ, unconditionally.
  - REQ: imem_valid = (count<DEPTH); imem_address = fetch_pc. On handshake (imem_valid & imem_ready): req_addr<=fetch_pc, req_off<=pend_off, pend_off<=0, fetch_pc<=fetch_pc+16, go to WAIT.
  - WAIT: imem_dp_ready=1. On imem_dp_valid: push {data, req_addr, req_off}, go to REQ.
  - DISCARD: imem_dp_ready=1. On imem_dp_valid: drop the response, go to REQ.
- imem_valid depends only on registered state and count, never on redirect_valid or imem_ready.
- One outstanding request maximum. A request is issued only when count<DEPTH, so a response always has a free slot; imem_dp_ready never deasserts in WAIT.
- Redirect handling (highest priority):
  - In every state: count<=0, pointers<=0, fetch_pc<={redirect_address[31:4],4'b0}, pend_off<=redirect_address[3:0].
  - REQ with no handshake: stay in REQ.
  - REQ with same-cycle handshake, or WAIT: go to DISCARD.
  - WAIT with same-cycle imem_dp_valid: response dropped, go to REQ.
  - DISCARD without response: stay in DISCARD with updated fetch_pc.
  - DISCARD with same-cycle response: response dropped, go to REQ.
  - IDLE: go to REQ with the new fetch_pc.
  - Same-cycle pop is ignored.
- Queue outputs: fq_valid=(count!=0); pop on fq_valid&fq_ready; push and pop in the same cycle leave count unchanged; pointers wrap modulo DEPTH.
- fetch_pc wraps from 32'hFFFFFFF0 to 32'h00000000 with no flag.
- Data latency: response accepted at edge N → fq_valid=1 after edge N (same cycle the registered entry appears).

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - perf_lines increments on each push.
  - perf_discards increments on each dropped response.
  - perf_full_stalls increments each cycle in REQ with count==DEPTH.
  - All three are 32-bit wrapping counters, cleared by reset only.
- Undefined: the three ports are present and tied to 0; no counter flops are synthesized.

Test Plan:
1. Reset, then imem_ready=1 and 1-cycle response latency, fq_ready=0 → requests at FFFFFFF0, 00000000, 00000010, 00000020; then imem_valid=0 with count=4; perf_full_stalls counts the stall cycles.
2. Redirect to 0x00001237 with the queue holding 3 entries → fq_valid=0 next cycle; next request is 0x00001230; that entry has fq_offset=7; the following entry is 0x00001240 with offset 0.
3. Redirect while in WAIT, response 3 cycles later carrying data A5A5... → response dropped (absent from the queue), perf_discards=1, next request at the redirect line.
4. Redirect in the same cycle as a REQ handshake → DISCARD entered; the stale response is dropped; the new-line request follows.
5. Queue at count=2 with pop and push in the same cycle → count stays 2; FIFO order preserved across pointer wrap (fill/drain 10 lines, addresses strictly +16).
6. Assert reset asynchronously mid-WAIT → all outputs 0 immediately; after release, state IDLE then REQ at FFFFFFF0; the late imem_dp_valid from the previous request is not enqueued.
